// File: rtl/alu_cmd_issuer.sv
// Issue stage for the 4-bit ALU: buffers commands, drives the ALU from the FIFO head and registers each answer into a valid/ready slot.
// Push-to-result latency is 2 edges at 1 result/cycle; a held result stalls issue, and a full FIFO drops in_ready.

module alu_cmd_issuer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             in_op,
    input  logic [3:0]             in_A,
    input  logic [3:0]             in_B,
    input  logic [1:0]             in_C,
    input  logic                   in_use_prev,
    output logic [1:0]             alu_op,
    output logic [3:0]             alu_inA,
    output logic [3:0]             alu_inB,
    output logic [1:0]             alu_inC,
    input  logic [3:0]             alu_ans,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [3:0]             out_ans,
    output logic [1:0]             out_op,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic [CNT_W-1:0]       issue_count
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [1:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] c;
        logic       use_prev;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, RUN, STALL} state_t;

    cmd_t             r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_out_valid;
    logic [3:0]       r_out_ans;
    logic [1:0]       r_out_op;
    logic [3:0]       r_last_ans;
    logic [CNT_W-1:0] r_issue_count;
    state_t           r_state;

    cmd_t             w_in_cmd;
    cmd_t             w_head;
    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_issue;
    logic             w_out_vld_nxt;
    logic [AW:0]      w_cnt_nxt;
    state_t           w_state_nxt;

    assign w_in_cmd = {in_op, in_A, in_B, in_C, in_use_prev};
    assign w_head   = r_mem[r_rd_ptr];
    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == (AW+1)'(DEPTH));

    // A push while full is dropped even if the head pops on the same edge.
    assign w_push        = in_valid && !w_full;
    assign w_issue       = !w_empty && (!r_out_valid || out_ready);
    assign w_out_vld_nxt = w_issue || (r_out_valid && !out_ready);

    always_comb begin
        w_cnt_nxt = r_count;
        if (w_push && !w_issue) begin
            w_cnt_nxt = r_count + (AW+1)'(1);
        end else if (!w_push && w_issue) begin
            w_cnt_nxt = r_count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_in_cmd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_out_valid   <= 1'b0;
            r_out_ans     <= '0;
            r_out_op      <= '0;
            r_last_ans    <= '0;
            r_issue_count <= '0;
        end else begin
            r_count <= w_cnt_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            // last_ans moves with the issue so a chained head sees it next cycle.
            if (w_issue) begin
                r_rd_ptr      <= r_rd_ptr + AW'(1);
                r_out_valid   <= 1'b1;
                r_out_ans     <= alu_ans;
                r_out_op      <= w_head.op;
                r_last_ans    <= alu_ans;
                r_issue_count <= r_issue_count + CNT_W'(1);
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_push) begin
                    w_state_nxt = RUN;
                end
            end
            RUN, STALL: begin
                if (w_cnt_nxt == '0 && !w_out_vld_nxt) begin
                    w_state_nxt = IDLE;
                end else if (w_out_vld_nxt && !out_ready && w_cnt_nxt != '0) begin
                    w_state_nxt = STALL;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = !w_full;
        alu_op   = '0;
        alu_inA  = '0;
        alu_inB  = '0;
        alu_inC  = '0;
        if (!w_empty) begin
            alu_op  = w_head.op;
            alu_inA = w_head.use_prev ? r_last_ans : w_head.a;
            alu_inB = w_head.b;
            alu_inC = w_head.c;
        end
    end

    assign out_valid   = r_out_valid;
    assign out_ans     = r_out_ans;
    assign out_op      = r_out_op;
    assign fifo_count  = r_count;
    assign issue_count = r_issue_count;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Randomized and directed bench for alu_cmd_issuer against a queue-based model of the issue stage.
module tb_alu_cmd_issuer;

    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    logic             clk         = 1'b0;
    logic             reset       = 1'b1;
    logic             in_valid    = 1'b0;
    logic             in_ready;
    logic [1:0]       in_op       = '0;
    logic [3:0]       in_A        = '0;
    logic [3:0]       in_B        = '0;
    logic [1:0]       in_C        = '0;
    logic             in_use_prev = 1'b0;
    logic [1:0]       alu_op;
    logic [3:0]       alu_inA;
    logic [3:0]       alu_inB;
    logic [1:0]       alu_inC;
    logic [3:0]       alu_ans;
    logic             out_valid;
    logic             out_ready   = 1'b0;
    logic [3:0]       out_ans;
    logic [1:0]       out_op;
    logic [2:0]       fifo_count;
    logic [CNT_W-1:0] issue_count;

    int n_chk  = 0;
    int n_pass = 0;

    alu_cmd_issuer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_A(in_A),
        .in_B(in_B), .in_C(in_C), .in_use_prev(in_use_prev),
        .alu_op(alu_op), .alu_inA(alu_inA), .alu_inB(alu_inB), .alu_inC(alu_inC),
        .alu_ans(alu_ans),
        .out_valid(out_valid), .out_ready(out_ready), .out_ans(out_ans), .out_op(out_op),
        .fifo_count(fifo_count), .issue_count(issue_count)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] alu_f(input logic [1:0] op, input logic [3:0] a,
                                         input logic [3:0] b, input logic [1:0] c);
        logic signed [3:0] s;
        s = a;
        case (op)
            2'b00:   return s >>> c;
            2'b01:   return a >> c;
            2'b10:   return a - b;
            default: return a + b;
        endcase
    endfunction

    // Combinational ALU seen by the DUT.
    always_comb alu_ans = alu_f(alu_op, alu_inA, alu_inB, alu_inC);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    endtask

    // Reference model: a queue of pending commands plus the output slot.
    typedef struct {
        logic [1:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] c;
        logic       up;
    } cmd_s;

    cmd_s             q[$];
    cmd_s             m_new;
    cmd_s             m_head;
    bit               m_push;
    bit               m_issue;
    bit               m_ovld = 1'b0;
    logic [3:0]       m_oans = '0;
    logic [3:0]       m_last = '0;
    logic [3:0]       m_res;
    logic [1:0]       m_oop  = '0;
    logic [CNT_W-1:0] m_icnt = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            m_ovld = 1'b0;
            m_oans = '0;
            m_oop  = '0;
            m_last = '0;
            m_icnt = '0;
        end else begin
            m_push   = in_valid && (q.size() < DEPTH);
            m_issue  = (q.size() > 0) && (!m_ovld || out_ready);
            m_new.op = in_op;
            m_new.a  = in_A;
            m_new.b  = in_B;
            m_new.c  = in_C;
            m_new.up = in_use_prev;
            if (m_issue) begin
                m_head = q.pop_front();
                m_res  = alu_f(m_head.op, m_head.up ? m_last : m_head.a, m_head.b, m_head.c);
                m_oans = m_res;
                m_oop  = m_head.op;
                m_ovld = 1'b1;
                m_last = m_res;
                m_icnt = m_icnt + 1'b1;
            end else if (m_ovld && out_ready) begin
                m_ovld = 1'b0;
            end
            if (m_push) q.push_back(m_new);
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            logic [1:0] e_op;
            logic [3:0] e_a;
            logic [3:0] e_b;
            logic [1:0] e_c;
            e_op = '0; e_a = '0; e_b = '0; e_c = '0;
            if (q.size() > 0) begin
                e_op = q[0].op;
                e_a  = q[0].up ? m_last : q[0].a;
                e_b  = q[0].b;
                e_c  = q[0].c;
            end
            chk("in_ready",    32'(in_ready),    32'(q.size() < DEPTH));
            chk("fifo_count",  32'(fifo_count),  32'(q.size()));
            chk("out_valid",   32'(out_valid),   32'(m_ovld));
            chk("out_ans",     32'(out_ans),     32'(m_oans));
            chk("out_op",      32'(out_op),      32'(m_oop));
            chk("issue_count", 32'(issue_count), 32'(m_icnt));
            chk("alu_op",      32'(alu_op),      32'(e_op));
            chk("alu_inA",     32'(alu_inA),     32'(e_a));
            chk("alu_inB",     32'(alu_inB),     32'(e_b));
            chk("alu_inC",     32'(alu_inC),     32'(e_c));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic v, input logic [1:0] op, input logic [3:0] a,
                           input logic [3:0] b, input logic [1:0] c, input logic up);
        in_valid    = v;
        in_op       = op;
        in_A        = a;
        in_B        = b;
        in_C        = c;
        in_use_prev = up;
    endtask

    task automatic single(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                          input logic [1:0] c, input logic [3:0] exp);
        set_cmd(1'b1, op, a, b, c, 1'b0);
        step();
        chk("single_not_yet_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b0;
        step();
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_ans",   32'(out_ans),   32'(exp));
        chk("single_op",    32'(out_op),    32'(op));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rdy_pct[4];
        rdy_pct = '{20, 50, 90, 100};

        #12;
        chk("rst_out_valid",   32'(out_valid),   32'd0);
        chk("rst_fifo_count",  32'(fifo_count),  32'd0);
        chk("rst_in_ready",    32'(in_ready),    32'd1);
        chk("rst_issue_count", 32'(issue_count), 32'd0);
        chk("rst_alu_inA",     32'(alu_inA),     32'd0);
        reset = 1'b0;
        step();

        out_ready = 1'b1;
        single(2'b00, 4'h8, 4'h0, 2'd1, 4'hC);
        single(2'b01, 4'h8, 4'h0, 2'd1, 4'h4);
        single(2'b10, 4'h3, 4'h5, 2'd0, 4'hE);
        single(2'b11, 4'h9, 4'h8, 2'd0, 4'h1);
        chk("single_issue_count", 32'(issue_count), 32'd4);

        set_cmd(1'b1, 2'b11, 4'h7, 4'h1, 2'd0, 1'b0);
        step();
        set_cmd(1'b1, 2'b00, 4'h0, 4'h0, 2'd2, 1'b1);
        step();
        chk("chain_first_ans", 32'(out_ans), 32'h8);
        chk("chain_fwd_inA",   32'(alu_inA), 32'h8);
        in_valid = 1'b0;
        step();
        chk("chain_second_ans", 32'(out_ans), 32'hE);
        step();

        out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            set_cmd(1'b1, 2'b11, 4'(i), 4'h1, 2'd0, 1'b0);
            step();
            if (i == 5) begin
                chk("bp_full_count", 32'(fifo_count), 32'd4);
                chk("bp_in_ready",   32'(in_ready),   32'd0);
            end
        end
        chk("bp_rejected_count", 32'(fifo_count), 32'd4);
        chk("bp_held_ans",       32'(out_ans),    32'h2);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("bp_drain_ans",   32'(out_ans),    32'(3 + k));
            chk("bp_drain_count", 32'(fifo_count), 32'(3 - k));
        end
        step();
        chk("bp_drained_valid", 32'(out_valid), 32'd0);

        out_ready = 1'b0;
        set_cmd(1'b1, 2'b10, 4'h9, 4'h1, 2'd0, 1'b0);
        step();
        set_cmd(1'b1, 2'b11, 4'h2, 4'h2, 2'd0, 1'b0);
        step();
        set_cmd(1'b1, 2'b01, 4'hF, 4'h0, 2'd3, 1'b0);
        step();
        chk("pp_pre_count", 32'(fifo_count), 32'd2);
        chk("pp_pre_ans",   32'(out_ans),    32'h8);
        set_cmd(1'b1, 2'b00, 4'h4, 4'h0, 2'd1, 1'b0);
        out_ready = 1'b1;
        step();
        chk("pp_same_count", 32'(fifo_count), 32'd2);
        chk("pp_ans_b",      32'(out_ans),    32'h4);
        in_valid = 1'b0;
        step();
        chk("pp_ans_c", 32'(out_ans), 32'h1);
        step();
        chk("pp_ans_d", 32'(out_ans), 32'h2);

        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_cmd(1'b1, 2'b11, 4'(i), 4'h5, 2'd0, 1'b0);
            step();
        end
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("midrst_out_valid",   32'(out_valid),   32'd0);
        chk("midrst_fifo_count",  32'(fifo_count),  32'd0);
        chk("midrst_issue_count", 32'(issue_count), 32'd0);
        chk("midrst_out_ans",     32'(out_ans),     32'd0);
        reset = 1'b0;
        step();
        out_ready = 1'b1;
        set_cmd(1'b1, 2'b11, 4'hF, 4'h3, 2'd0, 1'b1);
        step();
        in_valid = 1'b0;
        step();
        chk("midrst_chain_ans", 32'(out_ans), 32'h3);

        for (int s = 0; s < 4; s++) begin
            repeat (400) begin
                set_cmd(1'($urandom_range(0, 99) < 70), 2'($urandom_range(0, 3)),
                        4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                        2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
                out_ready = 1'($urandom_range(0, 99) < rdy_pct[s]);
                step();
            end
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (DEPTH + 3) step();
        #2 reset = 1'b1;
        #1 reset = 1'b0;
        step();
        for (int i = 0; i < 256; i++) begin
            set_cmd(1'b1, 2'b11, 4'(i), 4'h0, 2'd0, 1'b0);
            step();
        end
        chk("wrap_pre_count", 32'(issue_count), 32'd255);
        chk("wrap_stream_fifo", 32'(fifo_count), 32'd1);
        in_valid = 1'b0;
        step();
        chk("wrap_count_zero", 32'(issue_count), 32'd0);
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
